// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, idle control field values
// and the pipeline stage state encoding (state value doubles as entry count).
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Control bundle field values that leave architectural state untouched.
    localparam logic CTRL_REG_WRITE_DIS  = 1'b0;
    localparam logic CTRL_MEM_TO_REG_ALU = 1'b0;

    // Bit 0 = reg_write, bit 1 = mem_to_reg, upper bits (is_jal, dest) zero.
    localparam logic [7:0] CTRL_IDLE_DEFAULT = {6'b0, CTRL_MEM_TO_REG_ALU, CTRL_REG_WRITE_DIS};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        return logic'(s) == 1'b0 && s == ST_EMPTY ? 2'd0 : 2'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Second-entry storage for pipe_stage_reg, only instantiated when
// MIPS_PIPE_SKID_EN is defined. Holds the entry accepted while the head stalls.
module pipe_skid_buf
    import mips_pkg::*;
#(
    parameter int                    PAYLOAD_WIDTH = DATA_WIDTH,
    parameter int                    CTRL_WIDTH    = 8,
    parameter logic [CTRL_WIDTH-1:0] CTRL_IDLE     = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic [CTRL_WIDTH-1:0]    in_ctrl,
    output logic [PAYLOAD_WIDTH-1:0] payload,
    output logic [CTRL_WIDTH-1:0]    ctrl
);

    logic [PAYLOAD_WIDTH-1:0] skid_payload_p1;
    logic [CTRL_WIDTH-1:0]    skid_ctrl_p1;

    // A popped entry is cleared so a stale bundle can never leak back out.
    always_ff @(posedge clk) begin
        if (reset || flush || pop) begin
            skid_payload_p1 <= '0;
            skid_ctrl_p1    <= CTRL_IDLE;
        end else if (push) begin
            skid_payload_p1 <= in_payload;
            skid_ctrl_p1    <= in_ctrl;
        end
    end

    assign payload = skid_payload_p1;
    assign ctrl    = skid_ctrl_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic MIPS pipeline stage register with valid/ready handshake, flush and
// bubble squashing. Define MIPS_PIPE_SKID_EN to add a skid entry with registered in_ready.
module pipe_stage_reg
    import mips_pkg::*;
#(
    parameter int                    PAYLOAD_WIDTH = DATA_WIDTH,
    parameter int                    CTRL_WIDTH    = 8,
    parameter logic [CTRL_WIDTH-1:0] CTRL_IDLE     = CTRL_WIDTH'(CTRL_IDLE_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic [CTRL_WIDTH-1:0]    in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [CTRL_WIDTH-1:0]    out_ctrl,
    output logic [1:0]               occupancy
);

    pipe_state_e state, state_next;

    logic [PAYLOAD_WIDTH-1:0] main_payload_p1;
    logic [CTRL_WIDTH-1:0]    main_ctrl_p1;

    logic accept;
    logic emit;
    logic load_in;
    logic clear_main;

`ifdef MIPS_PIPE_SKID_EN
    logic                     in_ready_p1;
    logic                     load_skid;
    logic                     push_skid;
    logic                     pop_skid;
    logic [PAYLOAD_WIDTH-1:0] skid_payload;
    logic [CTRL_WIDTH-1:0]    skid_ctrl;

    // Back-pressure comes from a flop, breaking the out_ready -> in_ready path.
    assign in_ready = in_ready_p1;
`else
    assign in_ready = out_ready || !out_valid;
`endif

    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        state_next = state;
        load_in    = 1'b0;
        clear_main = 1'b0;
`ifdef MIPS_PIPE_SKID_EN
        load_skid  = 1'b0;
        push_skid  = 1'b0;
        pop_skid   = 1'b0;
`endif
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_MAIN;
                    load_in    = 1'b1;
                end
            end
            ST_MAIN: begin
                if (accept) begin
                    if (emit) begin
                        load_in = 1'b1;
                    end
`ifdef MIPS_PIPE_SKID_EN
                    else begin
                        state_next = ST_SKID;
                        push_skid  = 1'b1;
                    end
`endif
                end else if (emit) begin
                    state_next = ST_EMPTY;
                    clear_main = 1'b1;
                end
            end
`ifdef MIPS_PIPE_SKID_EN
            ST_SKID: begin
                if (emit) begin
                    state_next = ST_MAIN;
                    load_skid  = 1'b1;
                    pop_skid   = 1'b1;
                end
            end
`endif
            default: begin
                state_next = ST_EMPTY;
                clear_main = 1'b1;
            end
        endcase
    end

    // Stage boundary: state and head entry registers.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush || clear_main) begin
            main_payload_p1 <= '0;
            main_ctrl_p1    <= CTRL_IDLE;
        end else if (load_in) begin
            main_payload_p1 <= in_payload;
            main_ctrl_p1    <= in_ctrl;
        end
`ifdef MIPS_PIPE_SKID_EN
        else if (load_skid) begin
            main_payload_p1 <= skid_payload;
            main_ctrl_p1    <= skid_ctrl;
        end
`endif
    end

`ifdef MIPS_PIPE_SKID_EN
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            in_ready_p1 <= 1'b1;
        end else begin
            in_ready_p1 <= (state_next != ST_SKID);
        end
    end

    pipe_skid_buf #(
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .CTRL_WIDTH    (CTRL_WIDTH),
        .CTRL_IDLE     (CTRL_IDLE)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push_skid),
        .pop        (pop_skid),
        .in_payload (in_payload),
        .in_ctrl    (in_ctrl),
        .payload    (skid_payload),
        .ctrl       (skid_ctrl)
    );
`endif

    // Bubbles are squashed at the output so they can never write state downstream.
    assign out_payload = out_valid ? main_payload_p1 : '0;
    assign out_ctrl    = out_valid ? main_ctrl_p1 : CTRL_IDLE;
    assign occupancy   = state_occupancy(state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized self-checking bench for pipe_stage_reg; covers both
// the default build and the MIPS_PIPE_SKID_EN build.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_payload;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_payload;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;

    int vectors;
    int miscompares;

    pipe_stage_reg #(
        .PAYLOAD_WIDTH (32),
        .CTRL_WIDTH    (8),
        .CTRL_IDLE     (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_ctrl     (in_ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_ctrl    (out_ctrl),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1;
        in_payload = 32'hDEAD_BEEF; in_ctrl = 8'hFF; out_ready = 1'b0;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (out_ctrl !== 8'h00) begin miscompares++; $display("FAIL reset_out_ctrl: got %h want 00", out_ctrl); end
        vectors++;
        if (out_payload !== 32'h0) begin miscompares++; $display("FAIL reset_out_payload: got %h want 0", out_payload); end
        vectors++;
        if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        reset = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_payload = 32'(k); in_ctrl = 8'(k + 16);
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_payload !== 32'(k) || out_ctrl !== 8'(k + 16)) begin
                miscompares++;
                $display("FAIL stream_%0d: got v=%b p=%h c=%h want v=1 p=%h c=%h",
                         k, out_valid, out_payload, out_ctrl, 32'(k), 8'(k + 16));
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0) begin
            miscompares++;
            $display("FAIL stream_drain: got v=%b c=%h occ=%0d want v=0 c=00 occ=0", out_valid, out_ctrl, occupancy);
        end
    endtask

`ifdef MIPS_PIPE_SKID_EN
    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 32'hA; in_ctrl = 8'h1A;
        step();
        vectors++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_payload !== 32'hA) begin
            miscompares++; $display("FAIL bp_first: got occ=%0d rdy=%b p=%h want occ=1 rdy=1 p=a", occupancy, in_ready, out_payload);
        end
        in_payload = 32'hB; in_ctrl = 8'h1B;
        step();
        vectors++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_payload !== 32'hA) begin
            miscompares++; $display("FAIL bp_full: got occ=%0d rdy=%b p=%h want occ=2 rdy=0 p=a", occupancy, in_ready, out_payload);
        end
        in_payload = 32'hC; in_ctrl = 8'h1C;
        step();
        vectors++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_payload !== 32'hA || out_ctrl !== 8'h1A) begin
            miscompares++; $display("FAIL bp_hold: got occ=%0d rdy=%b p=%h c=%h want occ=2 rdy=0 p=a c=1a", occupancy, in_ready, out_payload, out_ctrl);
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_payload !== 32'hB || out_ctrl !== 8'h1B || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release_b: got p=%h c=%h occ=%0d rdy=%b want p=b c=1b occ=1 rdy=1", out_payload, out_ctrl, occupancy, in_ready);
        end
        step();
        vectors++;
        if (out_payload !== 32'hC || out_ctrl !== 8'h1C || occupancy !== 2'd1) begin
            miscompares++; $display("FAIL bp_release_c: got p=%h c=%h occ=%0d want p=c c=1c occ=1", out_payload, out_ctrl, occupancy);
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            miscompares++; $display("FAIL bp_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask
`else
    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 32'hA; in_ctrl = 8'h1A;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_payload !== 32'hA || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_stall: got v=%b p=%h rdy=%b want v=1 p=a rdy=0", out_valid, out_payload, in_ready);
        end
        in_payload = 32'hB; in_ctrl = 8'h1B;
        step();
        vectors++;
        if (occupancy !== 2'd1 || out_payload !== 32'hA || out_ctrl !== 8'h1A) begin
            miscompares++; $display("FAIL bp_hold: got occ=%0d p=%h c=%h want occ=1 p=a c=1a", occupancy, out_payload, out_ctrl);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_comb_ready: got %b want 1", in_ready); end
        step();
        vectors++;
        if (out_payload !== 32'hB || out_ctrl !== 8'h1B || occupancy !== 2'd1) begin
            miscompares++; $display("FAIL bp_pass: got p=%h c=%h occ=%0d want p=b c=1b occ=1", out_payload, out_ctrl, occupancy);
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            miscompares++; $display("FAIL bp_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask
`endif

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 32'hA; in_ctrl = 8'h2A;
        step();
`ifdef MIPS_PIPE_SKID_EN
        in_payload = 32'hB; in_ctrl = 8'h2B;
        step();
        vectors++;
        if (occupancy !== 2'd2) begin miscompares++; $display("FAIL flush_fill: got occ=%0d want 2", occupancy); end
`endif
        flush = 1'b1; out_ready = 1'b1; in_payload = 32'hD; in_ctrl = 8'h2D;
        step();
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_payload !== 32'h0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_empty: got occ=%0d v=%b p=%h c=%h rdy=%b want occ=0 v=0 p=0 c=00 rdy=1",
                     occupancy, out_valid, out_payload, out_ctrl, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || out_payload === 32'hD) begin
                miscompares++; $display("FAIL flush_no_d_%0d: got v=%b p=%h want v=0", i, out_valid, out_payload);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 32'h55; in_ctrl = 8'h33;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        vectors++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: got occ=%0d v=%b c=%h rdy=%b want occ=0 v=0 c=00 rdy=1", occupancy, out_valid, out_ctrl, in_ready);
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid_lost: got v=%b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] nxt;
        logic [31:0] exp_p;
        logic [31:0] seen_p;
        logic [7:0]  seen_c;
        logic        acc;
        logic        em;
        nxt = 32'h100;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_payload = nxt;
            in_ctrl    = nxt[7:0] ^ 8'hA5;
            out_ready  = ($urandom_range(0, 3) != 0);
            #1;
            vectors++;
            if (occupancy !== 2'(q.size())) begin
                miscompares++; $display("FAIL rand_occ cyc %0d: got %0d want %0d", cyc, occupancy, q.size());
            end
            if (!out_valid) begin
                vectors++;
                if (out_payload !== 32'h0 || out_ctrl !== 8'h00) begin
                    miscompares++; $display("FAIL rand_bubble cyc %0d: got p=%h c=%h want p=0 c=00", cyc, out_payload, out_ctrl);
                end
            end
            acc = in_valid && in_ready;
            em  = out_valid && out_ready;
            seen_p = out_payload;
            seen_c = out_ctrl;
            @(posedge clk);
            if (em) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++; $display("FAIL rand_dup cyc %0d: got p=%h want no entry", cyc, seen_p);
                end else begin
                    exp_p = q.pop_front();
                    if (seen_p !== exp_p || seen_c !== (exp_p[7:0] ^ 8'hA5)) begin
                        miscompares++;
                        $display("FAIL rand_order cyc %0d: got p=%h c=%h want p=%h c=%h", cyc, seen_p, seen_c, exp_p, exp_p[7:0] ^ 8'hA5);
                    end
                end
            end
            if (acc) begin
                q.push_back(nxt);
                nxt = nxt + 32'd1;
            end
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            miscompares++; $display("FAIL rand_final: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_payload = '0; in_ctrl = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
